// File: rtl/pdp8_pkg.sv
// Shared PDP-8 control definitions: op classes, PC width/reset vector and
// the pc_sequencer state encoding.
package pdp8_pkg;

    localparam int         PC_W         = 12;
    localparam logic [11:0] PC_RESET_VEC = 12'o0200;

    typedef enum logic [1:0] {
        OPC_NORMAL = 2'd0,
        OPC_SKIP   = 2'd1,
        OPC_JMP    = 2'd2,
        OPC_JMS    = 2'd3
    } op_class_t;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_LATCH    = 4'd1;
    localparam logic [3:0] ST_INC      = 4'd2;
    localparam logic [3:0] ST_DISPATCH = 4'd3;
    localparam logic [3:0] ST_SKIP     = 4'd4;
    localparam logic [3:0] ST_WRITE    = 4'd5;
    localparam logic [3:0] ST_LOAD     = 4'd6;
    localparam logic [3:0] ST_GAP      = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

endpackage

// File: rtl/pc_sequencer_if.sv
// ProgramCounter control bus plus the JMS return-address write port.
interface pc_sequencer_if #(parameter int PC_W = pdp8_pkg::PC_W);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_in;
    logic            pc_inc;
    logic            pc_load;
    logic            pc_latch;
    logic            mem_wr;
    logic [PC_W-1:0] mem_addr;
    logic [PC_W-1:0] mem_wdata;
    logic            mem_ack;

    modport master (
        input  pc, mem_ack,
        output pc_in, pc_inc, pc_load, pc_latch, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output pc, mem_ack,
        input  pc_in, pc_inc, pc_load, pc_latch, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/pc_sequencer.sv
// Per-instruction PC sequencer: latch, increment, conditional skip, JMP/JMS
// transfer with return-address store and a one-cycle-wide PC load pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; captures op_class/target on start
// LATCH    | pc_latch pulse (PCLAT <= PC)
// INC      | pc_inc pulse
// DISPATCH | decode op; SKIP samples skip_cond, JMS captures return addr
// SKIP     | second pc_inc pulse (skip taken)
// WRITE    | JMS return-address write, held until mem_ack or timeout
// LOAD     | pc_load pulse with pc_in = load value
// GAP      | pc_load low, pc_in held so the next load sees a clean edge
// DONE     | done strobe
module pc_sequencer #(
    parameter int PC_W        = pdp8_pkg::PC_W,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op_class,
    input  logic [PC_W-1:0] target,
    input  logic            skip_cond,
    pc_sequencer_if.master  bus,
    output logic            busy,
    output logic            done,
    output logic            err
);
    import pdp8_pkg::*;

    logic [3:0]      state;
    op_class_t       op_q;
    logic [PC_W-1:0] target_q;
    logic [PC_W-1:0] ret_q;
    logic [PC_W-1:0] load_q;
    logic [15:0]     tmo_q;
    logic            err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= OPC_NORMAL;
            target_q <= '0;
            ret_q    <= '0;
            load_q   <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q     <= op_class_t'(op_class);
                        target_q <= target;
                        err_q    <= 1'b0;
                        state    <= ST_LATCH;
                    end
                end
                ST_LATCH: state <= ST_INC;
                ST_INC:   state <= ST_DISPATCH;
                ST_DISPATCH: begin
                    case (op_q)
                        OPC_SKIP: state <= skip_cond ? ST_SKIP : ST_DONE;
                        OPC_JMP: begin
                            load_q <= target_q;
                            state  <= ST_LOAD;
                        end
                        OPC_JMS: begin
                            ret_q <= bus.pc;
                            tmo_q <= 16'(ACK_TIMEOUT - 1);
                            state <= ST_WRITE;
                        end
                        default: state <= ST_DONE;
                    endcase
                end
                ST_SKIP: state <= ST_DONE;
                ST_WRITE: begin
                    if (bus.mem_ack) begin
                        // JMS resumes at the word after the stored return address
                        load_q <= target_q + PC_W'(1);
                        state  <= ST_LOAD;
                    end else if (ACK_TIMEOUT != 0 && tmo_q == 16'd0) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q - 16'd1;
                    end
                end
                ST_LOAD: state <= ST_GAP;
                ST_GAP:  state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gating with reset drops the write request and load pulse in the reset cycle itself
    assign bus.pc_load   = (state == ST_LOAD) && !reset;
    assign bus.mem_wr    = (state == ST_WRITE) && !reset;
    assign bus.pc_latch  = (state == ST_LATCH);
    assign bus.pc_inc    = (state == ST_INC) || (state == ST_SKIP);
    assign bus.pc_in     = (state == ST_LOAD || state == ST_GAP) ? load_q : target_q;
    assign bus.mem_addr  = target_q;
    assign bus.mem_wdata = ret_q;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a ProgramCounter model and a memory
// model whose write ack arrives after a programmable number of cycles.
module tb_pc_sequencer;
    import pdp8_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op_class = 2'd0;
    logic [11:0] target = 12'd0;
    logic        skip_cond = 1'b0;
    logic        busy, done, err;

    int errors = 0;
    int checks = 0;

    pc_sequencer_if #(.PC_W(12)) bus ();

    pc_sequencer #(.PC_W(12), .ACK_TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_class  (op_class),
        .target    (target),
        .skip_cond (skip_cond),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ProgramCounter: loads only on a rising edge of pc_load
    logic [11:0] pc_r;
    logic [11:0] pclat_r;
    logic        load_prev;
    always @(posedge clk) begin
        if (reset) begin
            pc_r      <= 12'o0200;
            pclat_r   <= 12'o0000;
            load_prev <= 1'b0;
        end else begin
            load_prev <= bus.pc_load;
            if (bus.pc_latch) pclat_r <= pc_r;
            if (bus.pc_load && !load_prev) pc_r <= bus.pc_in;
            else if (bus.pc_inc) pc_r <= pc_r + 12'd1;
        end
    end
    assign bus.pc = pc_r;

    // Memory: ack once mem_wr has been high for ack_delay earlier cycles
    int          ack_delay = 0;
    logic        ack_en = 1'b0;
    int          wcnt = 0;
    int          wr_count = 0;
    logic [11:0] wr_addr = 12'd0;
    logic [11:0] wr_data = 12'd0;
    always @(posedge clk) begin
        if (reset || !bus.mem_wr) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (bus.mem_wr && bus.mem_ack) begin
            wr_addr  <= bus.mem_addr;
            wr_data  <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end
    end
    assign bus.mem_ack = ack_en && bus.mem_wr && (wcnt >= ack_delay);

    int          lat, latch_cyc, first_inc, inc_cycles, loads, load_cyc, overlap, wr_cycles;
    logic [11:0] pcin_load, pcin_gap;
    logic        idle_after;

    task automatic run_op(input logic [1:0] opc, input logic [11:0] tgt, input logic skc,
                          input int poke);
        lat = 0; latch_cyc = 0; first_inc = 0; inc_cycles = 0; loads = 0;
        load_cyc = 0; overlap = 0; wr_cycles = 0; pcin_load = '0; pcin_gap = '0;
        @(negedge clk);
        op_class = opc; target = tgt; skip_cond = skc; start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = (k == poke);
            if (bus.pc_latch && latch_cyc == 0) latch_cyc = k;
            if (bus.pc_inc) begin
                inc_cycles++;
                if (first_inc == 0) first_inc = k;
            end
            if (bus.pc_load) begin
                loads++; load_cyc = k; pcin_load = bus.pc_in;
            end
            if (load_cyc != 0 && k == load_cyc + 1) pcin_gap = bus.pc_in;
            if (bus.pc_inc && bus.pc_load) overlap++;
            if (bus.mem_wr) wr_cycles++;
            if (done) begin
                lat = k;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        idle_after = !busy;
        checks++;
        if (lat == 0) begin
            errors++; $display("FAIL done_timeout: no done within 60 cycles (op %0d)", opc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++; $display("FAIL reset_status: got %b want 000", {busy, done, err});
        end
        checks++;
        if ({bus.pc_inc, bus.pc_load, bus.pc_latch, bus.mem_wr} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b want 0000",
                               {bus.pc_inc, bus.pc_load, bus.pc_latch, bus.mem_wr});
        end
        checks++;
        if ({bus.pc_in, bus.mem_addr, bus.mem_wdata} !== 36'd0) begin
            errors++; $display("FAIL reset_buses: got %0o/%0o/%0o want 0/0/0",
                               bus.pc_in, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (pc_r !== 12'o0200) begin
            errors++; $display("FAIL reset_pc: got %0o want 200", pc_r);
        end
    endtask

    task automatic test_normal();
        run_op(OPC_NORMAL, 12'o1234, 1'b0, 0);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL normal_latency: got %0d want 4", lat); end
        checks++;
        if ({latch_cyc, first_inc, inc_cycles} !== {32'd1, 32'd2, 32'd1}) begin
            errors++; $display("FAIL normal_strobes: latch@%0d inc@%0d n=%0d want 1/2/1",
                               latch_cyc, first_inc, inc_cycles);
        end
        checks++;
        if ({pc_r, pclat_r} !== {12'o0201, 12'o0200}) begin
            errors++; $display("FAIL normal_pc: pc=%0o pclat=%0o want 201/200", pc_r, pclat_r);
        end
    endtask

    task automatic test_skip();
        run_op(OPC_JMP, 12'o0300, 1'b0, 0);
        run_op(OPC_SKIP, 12'o0000, 1'b1, 0);
        checks++;
        if ({lat, 20'(pc_r)} !== {32'd5, 20'o0302}) begin
            errors++; $display("FAIL skip_taken: lat=%0d pc=%0o want 5/302", lat, pc_r);
        end
        run_op(OPC_JMP, 12'o0300, 1'b0, 0);
        run_op(OPC_SKIP, 12'o0000, 1'b0, 0);
        checks++;
        if ({lat, 20'(pc_r)} !== {32'd4, 20'o0301}) begin
            errors++; $display("FAIL skip_not_taken: lat=%0d pc=%0o want 4/301", lat, pc_r);
        end
    endtask

    task automatic test_jmp();
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        run_op(OPC_JMP, 12'o4000, 1'b0, 0);
        checks++;
        if ({lat, loads, load_cyc, overlap} !== {32'd6, 32'd1, 32'd4, 32'd0}) begin
            errors++; $display("FAIL jmp_timing: lat=%0d loads=%0d load@%0d ovl=%0d want 6/1/4/0",
                               lat, loads, load_cyc, overlap);
        end
        checks++;
        if ({pc_r, pcin_load, pcin_gap} !== {12'o4000, 12'o4000, 12'o4000}) begin
            errors++; $display("FAIL jmp_pc: pc=%0o pc_in=%0o/%0o want 4000", pc_r, pcin_load, pcin_gap);
        end
    endtask

    task automatic test_jms();
        run_op(OPC_JMP, 12'o0500, 1'b0, 0);
        ack_en = 1'b1; ack_delay = 2;
        run_op(OPC_JMS, 12'o7777, 1'b0, 0);
        checks++;
        if ({wr_count, 12'(wr_addr), 12'(wr_data)} !== {32'd1, 12'o7777, 12'o0501}) begin
            errors++; $display("FAIL jms_write: n=%0d addr=%0o data=%0o want 1/7777/501",
                               wr_count, wr_addr, wr_data);
        end
        checks++;
        if ({lat, wr_cycles, loads, 20'(pc_r)} !== {32'd9, 32'd3, 32'd1, 20'o0000}) begin
            errors++; $display("FAIL jms_transfer: lat=%0d wr=%0d loads=%0d pc=%0o want 9/3/1/0",
                               lat, wr_cycles, loads, pc_r);
        end
        checks++;
        if (pcin_load !== 12'o0000 || err !== 1'b0) begin
            errors++; $display("FAIL jms_pc_in: pc_in=%0o err=%b want 0/0", pcin_load, err);
        end
        ack_delay = 0;
        run_op(OPC_JMS, 12'o0100, 1'b0, 0);
        checks++;
        if ({lat, wr_cycles, 20'(pc_r), 20'(wr_data)} !== {32'd7, 32'd1, 20'o0101, 20'o0001}) begin
            errors++; $display("FAIL jms_first_ack: lat=%0d wr=%0d pc=%0o data=%0o want 7/1/101/1",
                               lat, wr_cycles, pc_r, wr_data);
        end
    endtask

    task automatic test_jms_timeout();
        run_op(OPC_JMP, 12'o0500, 1'b0, 0);
        ack_en = 1'b0;
        run_op(OPC_JMS, 12'o2000, 1'b0, 0);
        checks++;
        if ({lat, wr_cycles, loads, 20'(pc_r)} !== {32'd19, 32'd15, 32'd0, 20'o0501}) begin
            errors++; $display("FAIL jms_timeout: lat=%0d wr=%0d loads=%0d pc=%0o want 19/15/0/501",
                               lat, wr_cycles, loads, pc_r);
        end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
        run_op(OPC_NORMAL, 12'o0000, 1'b0, 0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
    endtask

    task automatic test_busy_start();
        run_op(OPC_JMP, 12'o4000, 1'b0, 2);
        checks++;
        if ({lat, loads, 20'(pc_r)} !== {32'd6, 32'd1, 20'o4000}) begin
            errors++; $display("FAIL start_while_busy: lat=%0d loads=%0d pc=%0o want 6/1/4000",
                               lat, loads, pc_r);
        end
        run_op(OPC_JMP, 12'o1234, 1'b0, 6);
        checks++;
        if ({idle_after, 20'(pc_r)} !== {1'b1, 20'o1234}) begin
            errors++; $display("FAIL start_in_done: idle=%b pc=%0o want 1/1234", idle_after, pc_r);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        ack_en = 1'b0;
        @(negedge clk);
        op_class = OPC_JMS; target = 12'o3000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!bus.mem_wr && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL reach_write: mem_wr=%b want 1", bus.mem_wr); end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_drop_wr: got %b want 0", bus.mem_wr); end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({bus.mem_wr, busy, bus.pc_load, 12'(pc_r)} !== {3'b000, 12'o0200}) begin
            errors++; $display("FAIL reset_mid_write: wr=%b busy=%b load=%b pc=%0o want 0/0/0/200",
                               bus.mem_wr, busy, bus.pc_load, pc_r);
        end
        run_op(OPC_JMP, 12'o4000, 1'b0, 0);
        checks++;
        if ({loads, 20'(pc_r)} !== {32'd1, 20'o4000}) begin
            errors++; $display("FAIL b2b_first: loads=%0d pc=%0o want 1/4000", loads, pc_r);
        end
        run_op(OPC_JMP, 12'o0123, 1'b0, 0);
        checks++;
        if ({loads, lat, 20'(pc_r)} !== {32'd1, 32'd6, 20'o0123}) begin
            errors++; $display("FAIL b2b_second: loads=%0d lat=%0d pc=%0o want 1/6/123", loads, lat, pc_r);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_skip();
        test_jmp();
        test_jms();
        test_jms_timeout();
        test_busy_start();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
